// File: rtl/maxnet_pkg.sv
// Shared constants and types for the Maxnet datapath and its input loader.
package maxnet_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef logic [DATA_W-1:0] sample_t;
  typedef sample_t [NUM_IN-1:0] vector_t;
  typedef logic bank_sel_t;
  typedef logic [IDX_W-1:0] idx_t;

  // ReLU clamp applied to every incoming sample.
  function automatic sample_t relu(input sample_t s);
    return s[DATA_W-1] ? '0 : s;
  endfunction

endpackage

// File: rtl/maxnet_input_loader_if.sv
// Sample-stream and vector handshake bundle between upstream, loader and core.
interface maxnet_input_loader_if #(
  parameter int unsigned DATA_W = maxnet_pkg::DATA_W,
  parameter int unsigned NUM_IN = maxnet_pkg::NUM_IN
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic                     vec_valid;
  logic [NUM_IN*DATA_W-1:0] vec_data;
  logic                     vec_ready;

  // Loader side.
  modport slave (
    input  in_valid, in_data, vec_ready,
    output in_ready, vec_valid, vec_data
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, vec_ready,
    input  in_ready, vec_valid, vec_data
  );
endinterface

// File: rtl/maxnet_vector_bank.sv
// One NUM_IN-word register bank, clamps negatives to zero on write.
module maxnet_vector_bank #(
  parameter int unsigned DATA_W = maxnet_pkg::DATA_W,
  parameter int unsigned NUM_IN = maxnet_pkg::NUM_IN,
  parameter int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [NUM_IN*DATA_W-1:0] rd_data
);
  import maxnet_pkg::*;

  logic [NUM_IN-1:0][DATA_W-1:0] words;

  // Word storage; contents survive flush, only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words <= '0;
    end else if (wr_en) begin
      words[wr_idx] <= wr_data[DATA_W-1] ? '0 : wr_data;
    end
  end

  assign rd_data = words;

endmodule

// File: rtl/maxnet_input_loader.sv
// Groups a serial sample stream into NUM_IN-word vectors using two ping-pong banks.
module maxnet_input_loader #(
  parameter int unsigned DATA_W = maxnet_pkg::DATA_W,
  parameter int unsigned NUM_IN = maxnet_pkg::NUM_IN,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  maxnet_input_loader_if.slave   bus,
  output logic                   neg_seen,
  output logic [CNT_W-1:0]       vec_count
);
  import maxnet_pkg::*;

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  logic [1:0]               full;
  bank_sel_t                wr_bank;
  bank_sel_t                rd_bank;
  logic [IDX_W-1:0]         wr_idx;
  logic [NUM_IN*DATA_W-1:0] bank_data [2];
  logic                     in_fire;
  logic                     vec_fire;
  logic                     last_word;
  logic                     sample_neg;
  logic [1:0]               bank_we;

  // Handshakes are derived from registered flags only.
  always_comb begin
    bus.in_ready  = ~full[wr_bank];
    bus.vec_valid = full[rd_bank];
    bus.vec_data  = bank_data[rd_bank];
    in_fire       = bus.in_valid & ~full[wr_bank];
    vec_fire      = full[rd_bank] & bus.vec_ready;
    last_word     = (wr_idx == LAST_IDX);
    sample_neg    = bus.in_data[DATA_W-1];
    bank_we       = '0;
    if (in_fire && !flush) begin
      bank_we[wr_bank] = 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    maxnet_vector_bank #(
      .DATA_W (DATA_W),
      .NUM_IN (NUM_IN),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_we[b]),
      .wr_idx  (wr_idx),
      .wr_data (bus.in_data),
      .rd_data (bank_data[b])
    );
  end

  // Pointers, full flags and counters. A completing write and a drain always
  // touch different banks, so the two full-bit updates never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      neg_seen  <= 1'b0;
      vec_count <= '0;
    end else if (flush) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      neg_seen  <= 1'b0;
      vec_count <= '0;
    end else begin
      if (in_fire) begin
        if (sample_neg) begin
          neg_seen <= 1'b1;
        end
        if (last_word) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (vec_fire) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        vec_count     <= vec_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/maxnet_input_loader.md
Name: maxnet_input_loader

Overview:
- Upstream feeder for the Maxnet datapath. Accepts a serial stream of 32-bit samples over a valid/ready handshake and groups every NUM_IN consecutive samples into one vector.
- Each vector is presented in parallel to the datapath's input registers, which the datapath loads with its X/Tmp load strobes.
- Two ping-pong banks let the next vector fill while the core is still iterating on the current one.
- Negative samples are clamped to zero, matching the ReLU semantics of the core.

Parameters:
- DATA_W, 32, width of one sample.
- NUM_IN, 4, samples per vector; equals the number of Maxnet processing units.
- CNT_W, 16, width of the delivered-vector counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all buffered state.
- in_valid  in  1  upstream sample valid.
- in_data  in  DATA_W  upstream sample, two's complement.
- in_ready  out  1  loader can accept a sample this cycle.
- vec_valid  out  1  a complete vector is presented.
- vec_data  out  NUM_IN*DATA_W  vector; word k at bits [k*DATA_W +: DATA_W], word 0 = first sample received.
- vec_ready  in  1  core takes the vector this cycle (tied to the controller's ldX/ldTmp load).
- neg_seen  out  1  sticky: at least one negative sample was clamped since reset/flush.
- vec_count  out  CNT_W  number of vectors delivered (vec fires), wraps.

Behaviour:
- State:
  - bank0 and bank1, each NUM_IN x DATA_W.
  - full[1:0]
  - wr_bank, rd_bank, each 1 bit.
  - wr_idx, 0..NUM_IN-1.
  - neg_seen, vec_count.
- Reset (rst low, asynchronous): all state above = 0, bank contents = 0. in_ready=1, vec_valid=0, vec_data=0, neg_seen=0, vec_count=0.
- in_ready = !full[wr_bank], combinational from registered state only; no combinational path from in_valid.
- in_fire = in_valid & in_ready:
  - Stored word is 0 if in_data[DATA_W-1]=1, otherwise in_data.
  - Write goes to bank[wr_bank][wr_idx].
  - A negative sample also sets neg_seen.
  - If wr_idx = NUM_IN-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0. Otherwise wr_idx increments.
- vec_valid = full[rd_bank]; vec_data = bank[rd_bank]. Both are driven from registers, with no combinational path from vec_ready.
- vec_fire = vec_valid & vec_ready: full[rd_bank] <= 0, rd_bank toggles, vec_count increments (wraps from 2^CNT_W-1 to 0).
- vec_ready while vec_valid=0 is ignored.
- vec_data is stable while vec_valid=1 and no vec_fire occurs.
- Latency: the final sample of a vector accepted at edge N gives vec_valid=1 after edge N.
- Throughput: one sample per cycle is sustained indefinitely while the consumer drains a vector at least every NUM_IN cycles.
- Both banks full: in_ready=0 until a vec_fire.
  - A vec_fire frees rd_bank at that edge, and wr_bank equals rd_bank at that moment.
  - in_ready=1 in the following cycle, never in the same cycle.
- Simultaneous in_fire completing bank X and vec_fire on bank Y: always X≠Y, and both updates apply.
- Simultaneous in_fire (non-final) and vec_fire: both apply independently.
- flush (synchronous, active-high):
  - Same effect as reset, except bank contents need not be cleared.
  - Has priority over in_fire and vec_fire in the same cycle.
  - A vec_fire coinciding with flush is not counted.
- Partial vectors are never presented. A partial vector persists indefinitely until completed or flushed.
- Zero is a legal sample. An all-zero vector is delivered normally; handling it is the core's concern.

Decomposition:
- Shared package maxnet_pkg:
  - DATA_W and NUM_IN constants, shared with the datapath.
  - Sample typedef logic [DATA_W-1:0].
  - Vector typedef, an array of NUM_IN samples.
  - Bank-select and index typedefs.
- Sub-module maxnet_vector_bank, instantiated twice:
  - One NUM_IN-word register bank with write enable, write index, clamp-on-write and parallel read-out.
  - The top holds the pointers, full flags, handshakes and counters.

Test Plan:
- Reset, then samples 10, 20, 30, 40 on consecutive cycles with vec_ready=0:
  - vec_valid=1 the cycle after 40 is accepted.
  - vec_data words = 10, 20, 30, 40; in_ready stays 1 (bank1 empty).
- Stream 8 samples 1..8, vec_ready=0, then 1 more sample:
  - After 8, in_ready=0; the 9th is held off.
  - Assert vec_ready for one cycle: vector 1..4 leaves, vec_count=1.
  - in_ready=1 the next cycle; the following vector reads 5..8.
- Continuous input 1..16 with vec_ready pulsed each time vec_valid rises:
  - in_ready never drops.
  - Four vectors delivered in order; vec_count=4.
- Samples 5, -3 (32'hFFFFFFFD), 7, 0:
  - vec_data = 5, 0, 7, 0; neg_seen=1.
  - flush clears neg_seen and vec_valid.
- 2 samples (9, 9), then flush, then 4 samples 1, 2, 3, 4: delivered vector is 1, 2, 3, 4, with no stale 9s.
- rst low mid-fill with one full bank: all outputs return to reset values asynchronously, and the subsequent fill starts at bank0 word 0.
